drum_step_scheduler: RTL and testbench
======================================

DRUM_STEP_SCHEDULER -- requirements
Module: drum_step_scheduler

Interface
REQ-001 SHALL have parameter NUM_COLS, default 30, number of node columns sequenced.
REQ-002 SHALL have parameter DATA_W, default 18, signed 1.17 sample and coefficient width.
REQ-003 SHALL have port clock  in  1  rising-edge clock.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports run  in  1  enable stepping; strike  in  1  one-cycle request to re-initialise the mesh.
REQ-006 SHALL have ports param_wr  in  1, and rho_in, eta_in, gt_in  in  DATA_W each; the host coefficient write strobe and its values.
REQ-007 SHALL have ports rho, eta_term, g_tension  out  DATA_W each; coefficients driven to all columns.
REQ-008 SHALL have ports col_init  out  1  (pulse: columns reload initial shape) and col_start  out  1  (pulse: begin one time step).
REQ-009 SHALL have port col_done  in  NUM_COLS  per-column step/init-complete pulses, arriving in any order.
REQ-010 SHALL have port center_in  in  DATA_W  center-node amplitude of the mesh, valid when all columns are done.
REQ-011 SHALL have ports aud_data  out  DATA_W, aud_valid  out  1, aud_ready  in  1  (audio sample valid/ready handshake).
REQ-012 SHALL have ports step_count  out  32  (completed steps) and busy  out  1  (state not IDLE).
REQ-013 SHALL have ports step_cycles  out  16 and max_step_cycles  out  16 (timing monitor).

Function
REQ-014 SHALL implement FSM states IDLE, INIT, INIT_WAIT, START, STEP_WAIT, EMIT.
REQ-015 IDLE -> INIT on reset release or a pending strike; IDLE -> START when run=1 and no strike pending.
REQ-016 INIT SHALL assert col_init for exactly one cycle, clear the done mask, then enter INIT_WAIT.
REQ-017 START SHALL assert col_start for exactly one cycle, clear the done mask and the cycle counter, then enter STEP_WAIT.
REQ-018 A sticky NUM_COLS-bit done mask SHALL OR in col_done each cycle; a wait state exits the cycle after the mask is all ones.
REQ-019 INIT_WAIT exit SHALL go to START if run=1, else IDLE; STEP_WAIT exit SHALL latch center_in into aud_data and go to EMIT.
REQ-020 EMIT SHALL hold aud_valid=1 and aud_data stable until aud_ready=1; on that handshake cycle step_count increments by 1 (wrapping at 2^32).
REQ-021 After EMIT: pending strike -> INIT; else run=1 -> START; else IDLE.
REQ-022 strike SHALL be latched as pending in any state and serviced only at a step boundary; never aborts a step.
REQ-023 run falling mid-step SHALL let the current step and its EMIT complete before IDLE.
REQ-024 param_wr SHALL load shadow registers in any state; shadows SHALL copy to rho/eta_term/g_tension only in START and INIT, so coefficients are constant during a step.
REQ-025 Simultaneous param_wr and START: the new value SHALL be used for that step.
REQ-026 col_done bits set in START or while in IDLE/EMIT SHALL be ignored.
REQ-027 Minimum START-to-START latency with aud_ready=1 and all col_done in the first STEP_WAIT cycle SHALL be 4 cycles.

Reset
REQ-028 On reset: state IDLE, pending strike set, done mask 0, col_init=0, col_start=0, aud_valid=0, aud_data=0, step_count=0, busy=0, step_cycles=0, max_step_cycles=0.
REQ-029 On reset: rho=0x02000 (1/16), eta_term=0x00100, g_tension=0x00800; shadows equal.
REQ-030 Reset asserted mid-operation SHALL abandon any step or handshake within one cycle; aud_valid drops the next cycle.

Configuration
REQ-031 Macro DRUM_STEP_TIMING_EN defined: step_cycles counts clocks from col_start to done mask full (saturating at 0xFFFF), updated on exit from STEP_WAIT; max_step_cycles holds its running maximum.
REQ-032 Macro DRUM_STEP_TIMING_EN undefined: the counters are not built; step_cycles and max_step_cycles tie to 0.

Verification
REQ-033 Release reset, run=1, NUM_COLS=4, each column pulses done 5 cycles after col_init -> one col_init, then col_start; step_count=0.
REQ-034 Done bits in order 3,0,2,1 over 4 cycles -> STEP_WAIT exit only after bit 1; center_in=0x01234 -> aud_data=0x01234.
REQ-035 aud_ready low 10 cycles -> aud_valid and aud_data stable, no col_start; on ready, step_count +1.
REQ-036 strike mid-STEP_WAIT -> step completes and emits, then col_init (not col_start), then stepping resumes.
REQ-037 param_wr rho_in=0x04000 mid-step -> rho unchanged until next col_start cycle, then 0x04000.
REQ-038 DRUM_STEP_TIMING_EN defined, steps of 20 then 12 cycles -> step_cycles=12, max_step_cycles=20; undefined -> both 0.

Source files
------------

// File: rtl/drum_step_scheduler_if.sv
// Audio sample stream between the drum step scheduler and its consumer.
// The scheduler is the master: it presents a sample with aud_valid and
// holds it until the consumer answers with aud_ready.
interface drum_step_scheduler_if #(
    parameter int DATA_W = 18
);
    logic signed [DATA_W-1:0] aud_data;
    logic                     aud_valid;
    logic                     aud_ready;

    modport master (
        output aud_data,
        output aud_valid,
        input  aud_ready
    );

    modport slave (
        input  aud_data,
        input  aud_valid,
        output aud_ready
    );
endinterface

// File: rtl/drum_step_scheduler.sv
// Drum mesh step scheduler.
// Sequences NUM_COLS node columns through initialisation and time steps,
// collects their completion pulses, emits one centre-node audio sample per
// step over a valid/ready handshake and keeps coefficients constant within
// a step. Strikes are latched and only serviced between steps.
// Optional build macro: DRUM_STEP_TIMING_EN adds a per-step cycle counter
// (step_cycles) and its running maximum (max_step_cycles); without it both
// outputs are tied to zero.
module drum_step_scheduler #(
    parameter int NUM_COLS = 30,
    parameter int DATA_W   = 18
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     strike,
    input  logic                     param_wr,
    input  logic signed [DATA_W-1:0] rho_in,
    input  logic signed [DATA_W-1:0] eta_in,
    input  logic signed [DATA_W-1:0] gt_in,
    output logic signed [DATA_W-1:0] rho,
    output logic signed [DATA_W-1:0] eta_term,
    output logic signed [DATA_W-1:0] g_tension,
    output logic                     col_init,
    output logic                     col_start,
    input  logic [NUM_COLS-1:0]      col_done,
    input  logic signed [DATA_W-1:0] center_in,
    drum_step_scheduler_if.master    aud,
    output logic [31:0]              step_count,
    output logic                     busy,
    output logic [15:0]              step_cycles,
    output logic [15:0]              max_step_cycles
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        INIT_WAIT,
        START,
        STEP_WAIT,
        EMIT
    } state_t;

    // Power-on coefficients: rho = 1/16 in 1.17, small damping and tension.
    localparam logic signed [DATA_W-1:0] RHO_RST = DATA_W'(32'h0000_2000);
    localparam logic signed [DATA_W-1:0] ETA_RST = DATA_W'(32'h0000_0100);
    localparam logic signed [DATA_W-1:0] GT_RST  = DATA_W'(32'h0000_0800);

    state_t                   state;
    state_t                   state_nxt;
    logic                     strike_pend;
    logic [NUM_COLS-1:0]      done_mask;
    logic                     mask_full;
    logic                     coef_load;
    logic signed [DATA_W-1:0] rho_sh;
    logic signed [DATA_W-1:0] eta_sh;
    logic signed [DATA_W-1:0] gt_sh;
    logic signed [DATA_W-1:0] aud_data_r;

    // Wait states look at the registered mask, so exit is one cycle after
    // the last column reports.
    assign mask_full = &done_mask;
    // Coefficients only move at a step or init boundary.
    assign coef_load = (state == INIT) || (state == START);
    assign aud.aud_data = aud_data_r;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode and Moore outputs.
    always_comb begin
        state_nxt     = state;
        col_init      = 1'b0;
        col_start     = 1'b0;
        aud.aud_valid = 1'b0;
        busy          = (state != IDLE);
        case (state)
            IDLE: begin
                if (strike_pend) state_nxt = INIT;
                else if (run)    state_nxt = START;
            end
            INIT: begin
                col_init  = 1'b1;
                state_nxt = INIT_WAIT;
            end
            INIT_WAIT: begin
                if (mask_full) state_nxt = run ? START : IDLE;
            end
            START: begin
                col_start = 1'b1;
                state_nxt = STEP_WAIT;
            end
            STEP_WAIT: begin
                if (mask_full) state_nxt = EMIT;
            end
            EMIT: begin
                aud.aud_valid = 1'b1;
                if (aud.aud_ready) begin
                    if (strike_pend) state_nxt = INIT;
                    else if (run)    state_nxt = START;
                    else             state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strike request stays pending until an INIT services it; a strike that
    // arrives during INIT itself is kept for the next boundary.
    always_ff @(posedge clock) begin
        if (reset) strike_pend <= 1'b1;
        else       strike_pend <= strike | (strike_pend & (state != INIT));
    end

    // Sticky completion mask: cleared when columns are kicked, accumulated
    // only while waiting so stray pulses elsewhere are ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            done_mask <= '0;
        end else begin
            case (state)
                INIT, START:          done_mask <= '0;
                INIT_WAIT, STEP_WAIT: done_mask <= done_mask | col_done;
                default:              done_mask <= done_mask;
            endcase
        end
    end

    // Host-written shadow coefficients, accepted at any time.
    always_ff @(posedge clock) begin
        if (reset) begin
            rho_sh <= RHO_RST;
            eta_sh <= ETA_RST;
            gt_sh  <= GT_RST;
        end else if (param_wr) begin
            rho_sh <= rho_in;
            eta_sh <= eta_in;
            gt_sh  <= gt_in;
        end
    end

    // Live coefficients copy from the shadows at a boundary; a write in the
    // same cycle bypasses the shadow so that step already uses it.
    always_ff @(posedge clock) begin
        if (reset) begin
            rho       <= RHO_RST;
            eta_term  <= ETA_RST;
            g_tension <= GT_RST;
        end else if (coef_load) begin
            rho       <= param_wr ? rho_in : rho_sh;
            eta_term  <= param_wr ? eta_in : eta_sh;
            g_tension <= param_wr ? gt_in  : gt_sh;
        end
    end

    // Capture the centre-node amplitude as the step completes.
    always_ff @(posedge clock) begin
        if (reset)                               aud_data_r <= '0;
        else if (state == STEP_WAIT && mask_full) aud_data_r <= center_in;
    end

    // Count steps whose sample the consumer has taken.
    always_ff @(posedge clock) begin
        if (reset)                             step_count <= '0;
        else if (state == EMIT && aud.aud_ready) step_count <= step_count + 32'd1;
    end

`ifdef DRUM_STEP_TIMING_EN
    logic [15:0] cyc_cnt;
    logic [15:0] cyc_cnt_inc;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign cyc_cnt_inc = sat_inc16(cyc_cnt);

    // Clocks from col_start to the full mask, published when the step ends.
    always_ff @(posedge clock) begin
        if (reset) begin
            cyc_cnt         <= '0;
            step_cycles     <= '0;
            max_step_cycles <= '0;
        end else if (state == START) begin
            cyc_cnt <= '0;
        end else if (state == STEP_WAIT) begin
            cyc_cnt <= cyc_cnt_inc;
            if (mask_full) begin
                step_cycles <= cyc_cnt_inc;
                if (cyc_cnt_inc > max_step_cycles) max_step_cycles <= cyc_cnt_inc;
            end
        end
    end
`else
    assign step_cycles     = 16'd0;
    assign max_step_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_drum_step_scheduler.sv
// Bench for drum_step_scheduler: the bench plays the column mesh, the host
// and the audio consumer. A timeline model predicts every output each cycle
// from the done pulses it scheduled itself; directed sections pin the model
// with hand-derived literals.
module tb_drum_step_scheduler;
    localparam int NC = 4;
    localparam int DW = 18;
    localparam int P_IDLE = 0, P_INIT = 1, P_INITW = 2, P_START = 3, P_STEPW = 4, P_EMIT = 5;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, run, strike, param_wr;
    logic signed [DW-1:0] rho_in, eta_in, gt_in, rho, eta_term, g_tension, center_in;
    logic col_init, col_start, busy;
    logic [NC-1:0] col_done;
    logic [31:0] step_count;
    logic [15:0] step_cycles, max_step_cycles;

    drum_step_scheduler_if #(.DATA_W(DW)) aud_if ();

    drum_step_scheduler #(.NUM_COLS(NC), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset), .run(run), .strike(strike),
        .param_wr(param_wr), .rho_in(rho_in), .eta_in(eta_in), .gt_in(gt_in),
        .rho(rho), .eta_term(eta_term), .g_tension(g_tension),
        .col_init(col_init), .col_start(col_start), .col_done(col_done),
        .center_in(center_in), .aud(aud_if.master), .step_count(step_count),
        .busy(busy), .step_cycles(step_cycles), .max_step_cycles(max_step_cycles)
    );

    int errors = 0, checks = 0, cyc = 0;

    // Model state
    bit m_valid = 0, m_pend = 1;
    int ph = P_IDLE, m_start = 0, m_exit = 0, m_sc = 0, m_max = 0;
    int due [NC];
    logic signed [DW-1:0] m_rho, m_eta, m_gt, s_rho, s_eta, s_gt, m_aud;
    logic [31:0] m_cnt;

    // Observations of the DUT
    int n_init = 0, n_start = 0, n_emit = 0;
    int last_init_cyc = 0, last_start_cyc = 0, emit_cyc = 0;
    logic signed [DW-1:0] emit_data;
    logic [31:0] cnt_at_start;
    bit prev_valid = 0;

    // Stimulus knobs
    bit k_reset = 1, k_run = 0, k_strike_now = 0, k_param_now = 0, k_noise = 0, k_center_fix = 0;
    int k_ready = 1, k_strike_pm = 0, k_param_pct = 0, k_rflip_pm = 0, dmode = 2, dfix = 5, k_rmax = 8;
    logic signed [DW-1:0] k_rho_val, k_center;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int exp_sc();
`ifdef DRUM_STEP_TIMING_EN
        return m_sc;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_mx();
`ifdef DRUM_STEP_TIMING_EN
        return m_max;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        ph = P_IDLE; m_pend = 1; m_cnt = '0; m_aud = '0; m_sc = 0; m_max = 0;
        m_rho = DW'(32'h2000); m_eta = DW'(32'h100); m_gt = DW'(32'h800);
        s_rho = m_rho; s_eta = m_eta; s_gt = m_gt;
        for (int i = 0; i < NC; i++) due[i] = -1;
        m_valid = 1;
    endtask

    // One clock: check outputs, record events, drive inputs, advance model.
    task automatic step();
        int mx, nph;
        @(negedge clock);
        if (m_valid) begin
            chk("col_init", 64'(col_init), 64'(ph == P_INIT));
            chk("col_start", 64'(col_start), 64'(ph == P_START));
            chk("busy", 64'(busy), 64'(ph != P_IDLE));
            chk("aud_valid", 64'(aud_if.aud_valid), 64'(ph == P_EMIT));
            chk("aud_data", 64'(aud_if.aud_data), 64'(m_aud));
            chk("step_count", 64'(step_count), 64'(m_cnt));
            chk("step_cycles", 64'(step_cycles), 64'(exp_sc()));
            chk("max_step_cycles", 64'(max_step_cycles), 64'(exp_mx()));
            if (ph != P_START && ph != P_INIT) begin
                chk("rho", 64'(rho), 64'(m_rho));
                chk("eta_term", 64'(eta_term), 64'(m_eta));
                chk("g_tension", 64'(g_tension), 64'(m_gt));
            end
        end
        if (col_init === 1'b1) begin n_init++; last_init_cyc = cyc; end
        if (col_start === 1'b1) begin n_start++; last_start_cyc = cyc; cnt_at_start = step_count; end
        if (aud_if.aud_valid === 1'b1 && !prev_valid) begin
            n_emit++; emit_cyc = cyc; emit_data = aud_if.aud_data;
        end
        prev_valid = (aud_if.aud_valid === 1'b1);

        // Drive
        reset = k_reset;
        if (k_rflip_pm > 0 && $urandom_range(0, 999) < k_rflip_pm) k_run = !k_run;
        run = k_run;
        strike = k_strike_now || ($urandom_range(0, 999) < k_strike_pm);
        k_strike_now = 0;
        param_wr = k_param_now || ($urandom_range(0, 99) < k_param_pct);
        rho_in = k_param_now ? k_rho_val : DW'($urandom());
        eta_in = DW'($urandom());
        gt_in = DW'($urandom());
        k_param_now = 0;
        center_in = k_center_fix ? k_center : DW'($urandom());
        aud_if.aud_ready = (k_ready == 1) ? 1'b1 : (k_ready == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        if (m_valid && !k_reset && (ph == P_INIT || ph == P_START)) begin
            for (int i = 0; i < NC; i++) begin
                if (dmode == 0)      due[i] = cyc + 1 + $urandom_range(0, k_rmax);
                else if (dmode == 2) due[i] = cyc + dfix;
            end
            if (dmode == 1) begin
                due[3] = cyc + 1; due[0] = cyc + 2; due[2] = cyc + 3; due[1] = cyc + 4;
            end
            mx = due[0];
            for (int i = 1; i < NC; i++) if (due[i] > mx) mx = due[i];
            m_exit = mx + 1;
        end
        col_done = '0;
        for (int i = 0; i < NC; i++) if (due[i] == cyc) col_done[i] = 1'b1;
        if (k_noise && (ph == P_IDLE || ph == P_START || ph == P_EMIT)) col_done = col_done | NC'($urandom());

        // Advance model
        if (k_reset) begin
            model_reset();
        end else if (m_valid) begin
            nph = ph;
            case (ph)
                P_IDLE:  if (m_pend) nph = P_INIT; else if (run) nph = P_START;
                P_INIT:  nph = P_INITW;
                P_INITW: if (cyc == m_exit) nph = run ? P_START : P_IDLE;
                P_START: begin nph = P_STEPW; m_start = cyc; end
                P_STEPW: if (cyc == m_exit) begin
                    m_aud = center_in;
                    m_sc = (cyc - m_start > 65535) ? 65535 : cyc - m_start;
                    if (m_sc > m_max) m_max = m_sc;
                    nph = P_EMIT;
                end
                default: if (aud_if.aud_ready) begin
                    m_cnt = m_cnt + 1;
                    nph = m_pend ? P_INIT : (run ? P_START : P_IDLE);
                end
            endcase
            if (ph == P_INIT || ph == P_START) begin
                m_rho = param_wr ? rho_in : s_rho;
                m_eta = param_wr ? eta_in : s_eta;
                m_gt  = param_wr ? gt_in  : s_gt;
            end
            if (param_wr) begin s_rho = rho_in; s_eta = eta_in; s_gt = gt_in; end
            m_pend = strike || (m_pend && ph != P_INIT);
            ph = nph;
        end
        cyc++;
    endtask

    task automatic wait_start(input string nm, input int budget);
        int n0, k;
        n0 = n_start; k = 0;
        while (n_start == n0 && k < budget) begin step(); k++; end
        chk(nm, 64'(n_start != n0), 64'(1));
    endtask

    task automatic wait_emit(input string nm, input int budget);
        int n0, k;
        n0 = n_emit; k = 0;
        while (n_emit == n0 && k < budget) begin step(); k++; end
        chk(nm, 64'(n_emit != n0), 64'(1));
    endtask

    initial begin
        int sa, d0, c0, ni0, ns0, k;
        reset = 1; run = 0; strike = 0; param_wr = 0; rho_in = '0; eta_in = '0; gt_in = '0;
        center_in = '0; col_done = '0; aud_if.aud_ready = 1'b0;
        k_rho_val = '0; k_center = '0; emit_data = '0; cnt_at_start = '0;
        for (int i = 0; i < NC; i++) due[i] = -1;
        repeat (3) step();

        // Reset release with run: one init (dones 5 cycles later), then a step.
        k_reset = 0; k_run = 1; n_init = 0; n_start = 0;
        wait_start("first_start", 40);
        chk("init_pulses", 64'(n_init), 64'(1));
        chk("init_to_start", 64'(last_start_cyc - last_init_cyc), 64'(7));
        chk("count_at_first_start", 64'(cnt_at_start), 64'(0));

        // Done bits in order 3,0,2,1: exit only after bit 1, sample latched.
        dmode = 1; k_center_fix = 1; k_center = DW'(32'h01234);
        wait_start("order_start", 40);
        sa = last_start_cyc;
        wait_emit("order_emit", 40);
        chk("order_exit_latency", 64'(emit_cyc - sa), 64'(6));
        chk("order_aud_data", 64'(emit_data), 64'(DW'(32'h01234)));
        k_center_fix = 0;

        // Minimum start-to-start latency.
        dmode = 2; dfix = 1;
        wait_start("min_a", 40);
        sa = last_start_cyc;
        wait_start("min_b", 40);
        chk("min_latency", 64'(last_start_cyc - sa), 64'(4));

        // Consumer stalls: sample held, no new step.
        k_ready = 2; dfix = 3;
        wait_emit("stall_emit", 40);
        d0 = emit_data; c0 = step_count; ns0 = n_start;
        repeat (10) step();
        chk("stall_valid", 64'(aud_if.aud_valid), 64'(1));
        chk("stall_data", 64'(aud_if.aud_data), 64'(DW'(d0)));
        chk("stall_no_start", 64'(n_start), 64'(ns0));
        k_ready = 1;
        step(); step();
        chk("stall_count_inc", 64'(step_count), 64'(c0 + 1));

        // Strike mid-step: step finishes, then init instead of start.
        dfix = 6;
        wait_start("strike_start", 40);
        k_strike_now = 1;
        wait_emit("strike_emit", 40);
        ni0 = n_init; ns0 = n_start; k = 0;
        while (n_init == ni0 && n_start == ns0 && k < 20) begin step(); k++; end
        chk("strike_gives_init", 64'(n_init != ni0), 64'(1));
        chk("strike_no_start", 64'(n_start == ns0), 64'(1));
        wait_start("strike_resume", 40);

        // Mid-step coefficient write only takes effect at the next step.
        dfix = 8;
        wait_start("param_start", 40);
        chk("rho_before", 64'(rho), 64'(DW'(32'h02000)));
        k_param_now = 1; k_rho_val = DW'(32'h04000);
        step();
        wait_emit("param_emit", 40);
        chk("rho_held", 64'(rho), 64'(DW'(32'h02000)));
        wait_start("param_next", 40);
        step();
        chk("rho_new", 64'(rho), 64'(DW'(32'h04000)));

        // Reset during a stalled handshake.
        k_ready = 2; dfix = 2;
        wait_emit("rst_emit", 40);
        k_reset = 1; step(); k_reset = 0;
        k_ready = 1; dfix = 19; step();
        chk("rst_valid", 64'(aud_if.aud_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_count", 64'(step_count), 64'(0));
        chk("rst_rho", 64'(rho), 64'(DW'(32'h02000)));

        // Step timing monitor: steps of 20 then 12 cycles.
        wait_start("tim_a", 60);
        dfix = 11;
        wait_start("tim_b", 60);
        wait_emit("tim_emit", 40);
`ifdef DRUM_STEP_TIMING_EN
        chk("tim_last", 64'(step_cycles), 64'(12));
        chk("tim_max", 64'(max_step_cycles), 64'(20));
`else
        chk("tim_last", 64'(step_cycles), 64'(0));
        chk("tim_max", 64'(max_step_cycles), 64'(0));
`endif

        // Randomized traffic against the model.
        dmode = 0; k_rmax = 8; k_noise = 1; k_ready = 0;
        k_strike_pm = 15; k_param_pct = 10; k_rflip_pm = 20;
        repeat (4000) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
